// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and constants for the elastic pipeline stage.
//               State encoding, occupancy width and stall-counter limits.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // Three-state occupancy FSM of the two-entry elastic stage
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_t;

  localparam int OCC_W       = 2;
  localparam int STALL_CNT_W = 16;
  localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = {STALL_CNT_W{1'b1}};

  // Number of held entries implied by a state
  function automatic logic [OCC_W-1:0] occ_of(input pipe_state_t st);
    logic [OCC_W-1:0] occ;
    occ = '0;
    case (st)
      ST_HALF: occ = 2'd1;
      ST_FULL: occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// ============================================================================
// Module      : pipe_slot
// Description : One storage entry of the elastic stage: valid flag, control
//               field and data payload. A cleared slot becomes a bubble
//               (valid=0, ctrl=0) while the payload keeps its last value.
// Ports       : clk, reset (async, active-high)
//               clr            - turn the entry into a bubble (wins over load)
//               load           - capture d_ctrl/d_data and mark valid
//               d_ctrl, d_data - incoming entry
//               valid, ctrl, data - stored entry
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  load,
  input  logic [CTRL_WIDTH-1:0] d_ctrl,
  input  logic [DATA_WIDTH-1:0] d_data,
  output logic                  valid,
  output logic [CTRL_WIDTH-1:0] ctrl,
  output logic [DATA_WIDTH-1:0] data
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (clr) begin
      // Payload deliberately left untouched; only control is scrubbed
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= d_ctrl;
      data  <= d_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_stage_elastic.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_elastic
// Description : Generic two-entry elastic pipeline register (main + skid slot)
//               with valid/ready handshake, registered in_ready, synchronous
//               flush to bubbles and an optional back-pressure counter.
//               Optional feature macro: PIPE_STALL_CNT_EN
//                 defined   - stall_cnt counts out_valid & !out_ready cycles,
//                             saturating, cleared by reset only
//                 undefined - stall_cnt tied to zero
// Ports       : clk, reset (async, active-high), flush
//               in_valid/in_ready/in_data/in_ctrl     - upstream side
//               out_valid/out_ready/out_data/out_ctrl - downstream side
//               occupancy - held entries (0..2), stall_cnt - stall counter
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [CTRL_WIDTH-1:0]  in_ctrl,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [CTRL_WIDTH-1:0]  out_ctrl,
  output logic [OCC_W-1:0]       occupancy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  pipe_state_t            r_state;
  pipe_state_t            w_state_nxt;
  logic                   r_in_ready;
  logic [OCC_W-1:0]       r_occ;

  logic                   w_accept;
  logic                   w_drain;
  logic                   w_main_load;
  logic                   w_main_from_skid;
  logic                   w_main_clr;
  logic                   w_skid_load;
  logic                   w_skid_clr;

  logic                   w_skid_valid;
  logic [CTRL_WIDTH-1:0]  w_skid_ctrl;
  logic [DATA_WIDTH-1:0]  w_skid_data;
  logic [CTRL_WIDTH-1:0]  w_main_d_ctrl;
  logic [DATA_WIDTH-1:0]  w_main_d_data;

  assign w_accept = in_valid & r_in_ready;
  assign w_drain  = out_valid & out_ready;

  // Slot steering. Flush overrides everything; a drain in the flush cycle
  // still completes on the wires, it simply leaves nothing behind.
  always_comb begin
    w_state_nxt      = r_state;
    w_main_load      = 1'b0;
    w_main_from_skid = 1'b0;
    w_main_clr       = 1'b0;
    w_skid_load      = 1'b0;
    w_skid_clr       = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_main_clr  = 1'b1;
      w_skid_clr  = 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_main_load = 1'b1;
            w_state_nxt = ST_HALF;
          end
        end
        ST_HALF: begin
          if (w_accept && w_drain) begin
            w_main_load = 1'b1;
          end else if (w_accept) begin
            w_skid_load = 1'b1;
            w_state_nxt = ST_FULL;
          end else if (w_drain) begin
            w_main_clr  = 1'b1;
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only a drain can move the state
          if (w_drain) begin
            w_main_load      = 1'b1;
            w_main_from_skid = 1'b1;
            w_skid_clr       = 1'b1;
            w_state_nxt      = ST_HALF;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  assign w_main_d_ctrl = w_main_from_skid ? w_skid_ctrl : in_ctrl;
  assign w_main_d_data = w_main_from_skid ? w_skid_data : in_data;

  // in_ready and occupancy are registered from the next state so that
  // out_ready never reaches in_ready combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
      r_occ      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != ST_FULL);
      r_occ      <= occ_of(w_state_nxt);
    end
  end

  pipe_slot #(
    .DATA_WIDTH (DATA_WIDTH),
    .CTRL_WIDTH (CTRL_WIDTH)
  ) u_main (
    .clk    (clk),
    .reset  (reset),
    .clr    (w_main_clr),
    .load   (w_main_load),
    .d_ctrl (w_main_d_ctrl),
    .d_data (w_main_d_data),
    .valid  (out_valid),
    .ctrl   (out_ctrl),
    .data   (out_data)
  );

  pipe_slot #(
    .DATA_WIDTH (DATA_WIDTH),
    .CTRL_WIDTH (CTRL_WIDTH)
  ) u_skid (
    .clk    (clk),
    .reset  (reset),
    .clr    (w_skid_clr),
    .load   (w_skid_load),
    .d_ctrl (in_ctrl),
    .d_data (in_data),
    .valid  (w_skid_valid),
    .ctrl   (w_skid_ctrl),
    .data   (w_skid_data)
  );

  assign in_ready  = r_in_ready;
  assign occupancy = r_occ;

`ifdef PIPE_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (out_valid && !out_ready && (r_stall_cnt != STALL_CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

  a_occ_never_3: assert property (@(posedge clk) disable iff (reset)
    occupancy != 2'b11);

  // Skid holds an entry exactly when the FSM says FULL
  a_skid_matches_state: assert property (@(posedge clk) disable iff (reset)
    w_skid_valid == (r_state == ST_FULL));

endmodule
`default_nettype wire
